fractal_iter: RTL and testbench
===============================

FRACTAL_ITER -- requirements
Module: fractal_iter

Interface
REQ-001 The block SHALL have parameter FP_WIDTH, default 25, total fixed-point width (integer + fractional bits).
REQ-002 The block SHALL have parameter FP_INT, default 4, integer bits; FBITS = FP_WIDTH-FP_INT (1.0 = 0x200000 at defaults).
REQ-003 The block SHALL have parameter ITERW, default 8, width of the iteration count and limit.
REQ-004 The block SHALL have parameter TAGW, default 16, width of the pass-through job tag.
REQ-005 The block SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port in_valid  in  1  job request valid.
REQ-008 The block SHALL have port in_ready  out  1  block can accept a job.
REQ-009 The block SHALL have port mode  in  1  0 = Mandelbrot, 1 = Julia.
REQ-010 The block SHALL have ports re, im  in  FP_WIDTH signed  pixel coordinate.
REQ-011 The block SHALL have ports c_re, c_im  in  FP_WIDTH signed  Julia constant, ignored in Mandelbrot mode.
REQ-012 The block SHALL have port iter_max  in  ITERW  runtime iteration limit.
REQ-013 The block SHALL have port in_tag  in  TAGW  job tag.
REQ-014 The block SHALL have port out_valid  out  1  result valid.
REQ-015 The block SHALL have port out_ready  in  1  result consumer ready.
REQ-016 The block SHALL have ports out_iter  out  ITERW, out_escaped  out  1, out_tag  out  TAGW  result fields.
REQ-017 The block SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-018 Accept SHALL occur on in_valid && in_ready; mode, re, im, c_re, c_im, iter_max and in_tag are registered on accept and later input changes are ignored.
REQ-019 in_ready SHALL equal (state == IDLE) and SHALL fall the cycle after accept.
REQ-020 Initial values SHALL be: Mandelbrot z0 = 0, c = (re,im); Julia z0 = (re,im), c = (c_re,c_im); iter = 0.
REQ-021 The FSM SHALL be IDLE -> SQX -> SQY -> XY -> TEST -> (SQX | OUT) -> IDLE.
REQ-022 SQX, SQY and XY SHALL each pulse mul start for one cycle with operands (x,x), (y,y) and (x,y) respectively, and advance on mul done.
REQ-023 TEST SHALL compute x2+y2 at FP_WIDTH+1 bits (no wrap) and set escaped when that sum > 4.0 (strict, full precision) or when any of the three multiplies in this pass raised ovf.
REQ-024 TEST: if escaped -> OUT with out_escaped = 1; else if iter == iter_max -> OUT with out_escaped = 0; else x <= x2-y2+c_re, y <= 2*xy+c_im (FP_WIDTH wrap), iter <= iter+1 -> SQX.
REQ-025 out_iter SHALL be the iter value at the TEST that exits; iter_max = 0 SHALL give exactly one TEST and out_iter = 0.
REQ-026 out_valid SHALL rise the cycle after the exiting TEST; out_iter, out_escaped and out_tag SHALL be stable while out_valid && !out_ready.
REQ-027 On out_valid && out_ready the FSM SHALL go to IDLE; in_ready SHALL rise the next cycle (no same-cycle accept).

Reset
REQ-028 rst_n low SHALL force, asynchronously: state IDLE, out_valid 0, busy 0, out_iter 0, out_escaped 0, out_tag 0, in_ready 1 after release.
REQ-029 Reset mid-job SHALL abandon the job with no result emitted, and SHALL drive the mul instance reset (rst = !rst_n).

Structure
REQ-030 Package fractal_pkg SHALL hold the FSM state enum and the mode constants MODE_MANDEL = 0 and MODE_JULIA = 1.
REQ-031 Exactly one sub-module SHALL be used: the team's fixed-point multiplier mul, parameters WIDTH = FP_WIDTH, FBITS = FP_WIDTH-FP_INT, with its done and ovf outputs connected.

Verification
REQ-032 The bench SHALL drive Mandelbrot, c = 0, iter_max = 255 and require out_iter = 255, out_escaped = 0.
REQ-033 The bench SHALL drive Mandelbrot, c = (2.0,0), iter_max = 255 and require out_iter = 2, out_escaped = 1 (|z1|^2 = 4.0 does not escape).
REQ-034 The bench SHALL drive Julia, z0 = (2.5,0), c = (0,0), iter_max = 255 and require out_iter = 0, out_escaped = 1.
REQ-035 The bench SHALL drive iter_max = 0, Mandelbrot, c = 0 and require out_iter = 0, out_escaped = 0.
REQ-036 The bench SHALL hold out_ready low for 10 cycles with tag 0xBEEF and require out_valid and all result fields stable, in_ready = 0, and a held in_valid accepted only after the output handshake.
REQ-037 The bench SHALL pull rst_n low mid-job (c = 0, iter_max = 255) and require out_valid = 0 immediately, no result emitted, and a following job with c = (2.0,0) returning out_iter = 2.

Source files
------------

// File: rtl/fractal_pkg.sv
// Shared types for the escape-time fractal iterator: FSM state encoding and job mode values.
package fractal_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SQX, S_SQY, S_XY, S_TEST, S_OUT} state_e;
  localparam logic MODE_MANDEL = 1'b0;
  localparam logic MODE_JULIA  = 1'b1;
endpackage

// File: rtl/mul.sv
// Signed fixed-point multiplier: result and done one cycle after start, ovf when the
// rescaled product does not fit in WIDTH signed bits.
module mul #(
  parameter int WIDTH = 25,
  parameter int FBITS = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p,
  output logic                    done,
  output logic                    ovf
);
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] sh;
  logic                      ovf_c;

  assign prod  = a * b;
  assign sh    = prod >>> FBITS;
  // Everything above the result sign bit must be pure sign extension.
  assign ovf_c = (sh[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){sh[WIDTH-1]}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p    <= '0;
      done <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        p   <= sh[WIDTH-1:0];
        ovf <= ovf_c;
      end
    end
  end
endmodule

// File: rtl/fractal_iter.sv
// Escape-time iterator for one pixel (Mandelbrot or Julia) using a single shared
// multiplier for x*x, y*y and x*y per pass, with valid/ready job and result handshakes.
module fractal_iter
  import fractal_pkg::*;
#(
  parameter int FP_WIDTH = 25,
  parameter int FP_INT   = 4,
  parameter int ITERW    = 8,
  parameter int TAGW     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mode,
  input  logic signed [FP_WIDTH-1:0] re,
  input  logic signed [FP_WIDTH-1:0] im,
  input  logic signed [FP_WIDTH-1:0] c_re,
  input  logic signed [FP_WIDTH-1:0] c_im,
  input  logic        [ITERW-1:0]    iter_max,
  input  logic        [TAGW-1:0]     in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [ITERW-1:0]    out_iter,
  output logic                       out_escaped,
  output logic        [TAGW-1:0]     out_tag,
  output logic                       busy
);
  localparam int FBITS = FP_WIDTH - FP_INT;
  localparam logic signed [FP_WIDTH:0] FOUR =
    {{(FP_WIDTH-FBITS-2){1'b0}}, 3'b100, {FBITS{1'b0}}};

  state_e state_q, state_d;
  logic signed [FP_WIDTH-1:0] x_q, x_d, y_q, y_d, cre_q, cre_d, cim_q, cim_d;
  logic signed [FP_WIDTH-1:0] x2_q, x2_d, y2_q, y2_d, xy_q, xy_d;
  logic [ITERW-1:0] iter_q, iter_d, itmax_q, itmax_d, oiter_q, oiter_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic ovf_q, ovf_d, pend_q, pend_d, oesc_q, oesc_d;

  logic                       mul_start, mul_done, mul_ovf;
  logic signed [FP_WIDTH-1:0] mul_a, mul_b, mul_p;
  logic signed [FP_WIDTH:0]   mag;
  logic                       escaped;

  mul #(.WIDTH(FP_WIDTH), .FBITS(FBITS)) u_mul (
    .clk(clk), .rst(!rst_n), .start(mul_start), .a(mul_a), .b(mul_b),
    .p(mul_p), .done(mul_done), .ovf(mul_ovf)
  );

  // One extra bit so the sum of two squares never wraps before the compare.
  assign mag     = {x2_q[FP_WIDTH-1], x2_q} + {y2_q[FP_WIDTH-1], y2_q};
  assign escaped = (mag > FOUR) || ovf_q;

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_OUT);
  assign out_iter    = oiter_q;
  assign out_escaped = oesc_q;
  assign out_tag     = tag_q;

  always_comb begin
    state_d = state_q;
    x_d = x_q;  y_d = y_q;  cre_d = cre_q;  cim_d = cim_q;
    x2_d = x2_q;  y2_d = y2_q;  xy_d = xy_q;
    iter_d = iter_q;  itmax_d = itmax_q;  oiter_d = oiter_q;  oesc_d = oesc_q;
    tag_d = tag_q;  ovf_d = ovf_q;  pend_d = pend_q;
    mul_start = 1'b0;
    mul_a = x_q;
    mul_b = x_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_SQX;
        iter_d  = '0;
        ovf_d   = 1'b0;
        tag_d   = in_tag;
        itmax_d = iter_max;
        if (mode == MODE_JULIA) begin
          x_d = re;  y_d = im;  cre_d = c_re;  cim_d = c_im;
        end else begin
          x_d = '0;  y_d = '0;  cre_d = re;  cim_d = im;
        end
      end
      S_SQX, S_SQY, S_XY: begin
        if (state_q == S_SQY) begin
          mul_a = y_q;  mul_b = y_q;
        end else if (state_q == S_XY) begin
          mul_b = y_q;
        end
        mul_start = !pend_q;
        if (!pend_q) pend_d = 1'b1;
        if (mul_done) begin
          pend_d = 1'b0;
          ovf_d  = ovf_q | mul_ovf;
          case (state_q)
            S_SQX:   begin x2_d = mul_p; state_d = S_SQY;  end
            S_SQY:   begin y2_d = mul_p; state_d = S_XY;   end
            default: begin xy_d = mul_p; state_d = S_TEST; end
          endcase
        end
      end
      S_TEST: begin
        if (escaped || iter_q == itmax_q) begin
          oiter_d = iter_q;
          oesc_d  = escaped;
          state_d = S_OUT;
        end else begin
          x_d     = x2_q - y2_q + cre_q;
          y_d     = {xy_q[FP_WIDTH-2:0], 1'b0} + cim_q;
          iter_d  = iter_q + ITERW'(1);
          ovf_d   = 1'b0;
          state_d = S_SQX;
        end
      end
      S_OUT: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q <= '0;  y_q <= '0;  cre_q <= '0;  cim_q <= '0;
      x2_q <= '0;  y2_q <= '0;  xy_q <= '0;
      iter_q <= '0;  itmax_q <= '0;  oiter_q <= '0;  oesc_q <= 1'b0;
      tag_q <= '0;  ovf_q <= 1'b0;  pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;  y_q <= y_d;  cre_q <= cre_d;  cim_q <= cim_d;
      x2_q <= x2_d;  y2_q <= y2_d;  xy_q <= xy_d;
      iter_q <= iter_d;  itmax_q <= itmax_d;  oiter_q <= oiter_d;  oesc_q <= oesc_d;
      tag_q <= tag_d;  ovf_q <= ovf_d;  pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_fractal_iter.sv
// Directed bench for fractal_iter: known escape counts, limits, backpressure and mid-job reset.
module tb_fractal_iter;
  localparam int W = 25;
  localparam logic signed [W-1:0] ZERO = 25'h0;
  localparam logic signed [W-1:0] TWO  = 25'h0400000;
  localparam logic signed [W-1:0] TWO5 = 25'h0500000;
  localparam logic signed [W-1:0] MONE = -25'sh0200000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, mode = 1'b0;
  logic signed [W-1:0] re = '0, im = '0, c_re = '0, c_im = '0;
  logic [7:0]  iter_max = '0, out_iter;
  logic [15:0] in_tag = '0, out_tag;
  logic out_valid, out_ready = 1'b1, out_escaped, busy;
  int checks = 0, fails = 0;

  fractal_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .re(re), .im(im), .c_re(c_re), .c_im(c_im), .iter_max(iter_max), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_iter(out_iter),
    .out_escaped(out_escaped), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(logic md, logic signed [W-1:0] r, logic signed [W-1:0] i,
                       logic signed [W-1:0] cr, logic signed [W-1:0] ci,
                       logic [7:0] im_max, logic [15:0] tg);
    mode = md;  re = r;  im = i;  c_re = cr;  c_im = ci;  iter_max = im_max;  in_tag = tg;
    in_valid = 1'b1;
  endtask

  task automatic send(logic md, logic signed [W-1:0] r, logic signed [W-1:0] i,
                      logic signed [W-1:0] cr, logic signed [W-1:0] ci,
                      logic [7:0] im_max, logic [15:0] tg);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    drive(md, r, i, cr, ci, im_max, tg);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode = ~md;  re = 25'h1;  im = 25'h1;  c_re = 25'h1;  c_im = 25'h1;  in_tag = ~tg;
    chk("ready_fall", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 5000) begin @(negedge clk); n++; end
    chk("out_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run(string nm, logic md, logic signed [W-1:0] r, logic signed [W-1:0] i,
                     logic signed [W-1:0] cr, logic signed [W-1:0] ci, logic [7:0] im_max,
                     logic [15:0] tg, logic [7:0] e_it, logic e_esc);
    send(md, r, i, cr, ci, im_max, tg);
    wait_out();
    chk({nm, "_iter"}, {24'd0, out_iter}, {24'd0, e_it});
    chk({nm, "_esc"},  {31'd0, out_escaped}, {31'd0, e_esc});
    chk({nm, "_tag"},  {16'd0, out_tag}, {16'd0, tg});
    @(posedge clk); #1;
    chk({nm, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    chk("rst_vld",  {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_iter", {24'd0, out_iter}, 32'd0);
    chk("rst_esc",  {31'd0, out_escaped}, 32'd0);
    chk("rst_tag",  {16'd0, out_tag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    run("m_c0",    1'b0, ZERO, ZERO, ZERO, ZERO, 8'd255, 16'h0001, 8'd255, 1'b0);
    run("m_c2",    1'b0, TWO,  ZERO, ZERO, ZERO, 8'd255, 16'h0002, 8'd2,   1'b1);
    run("j_25",    1'b1, TWO5, ZERO, ZERO, ZERO, 8'd255, 16'h0003, 8'd0,   1'b1);
    run("m_max0",  1'b0, ZERO, ZERO, ZERO, ZERO, 8'd0,   16'h0004, 8'd0,   1'b0);
    run("m_cm1",   1'b0, MONE, ZERO, ZERO, ZERO, 8'd5,   16'h0005, 8'd5,   1'b0);
    run("m_ign_c", 1'b0, ZERO, ZERO, TWO5, TWO,  8'd3,   16'h0006, 8'd3,   1'b0);

    // Backpressure: result held, a pending job waits for the output handshake.
    out_ready = 1'b0;
    send(1'b0, TWO, ZERO, ZERO, ZERO, 8'd255, 16'hBEEF);
    wait_out();
    drive(1'b1, TWO5, ZERO, ZERO, ZERO, 8'd255, 16'h1234);
    for (int k = 0; k < 10; k++) begin
      chk("bp_vld",  {31'd0, out_valid}, 32'd1);
      chk("bp_iter", {24'd0, out_iter}, 32'd2);
      chk("bp_esc",  {31'd0, out_escaped}, 32'd1);
      chk("bp_tag",  {16'd0, out_tag}, 32'hBEEF);
      chk("bp_rdy",  {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_vld_drop", {31'd0, out_valid}, 32'd0);
    chk("bp_rdy_rise", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", {31'd0, busy}, 32'd1);
    wait_out();
    chk("bp2_iter", {24'd0, out_iter}, 32'd0);
    chk("bp2_esc",  {31'd0, out_escaped}, 32'd1);
    chk("bp2_tag",  {16'd0, out_tag}, 32'h1234);
    @(posedge clk); #1;

    // Mid-job reset abandons the job.
    send(1'b0, ZERO, ZERO, ZERO, ZERO, 8'd255, 16'h0BAD);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 2200; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_result", seen, 0);
    run("post_rst", 1'b0, TWO, ZERO, ZERO, ZERO, 8'd255, 16'h0007, 8'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
